scroll_ctrl: RTL and testbench
==============================

SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 SHALL have parameter MSG_DEPTH, default 16, meaning message buffer entries (power of 2).
REQ-002 SHALL have parameter SYM_W, default 5, meaning symbol code width.
REQ-003 SHALL have port iCLK, input, 1, the single clock; all logic on posedge iCLK.
REQ-004 SHALL have port iRST, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port iWR_EN, input, 1, message buffer write strobe.
REQ-006 SHALL have port iWR_ADDR, input, 4, write address.
REQ-007 SHALL have port iWR_DATA, input, SYM_W, write symbol.
REQ-008 SHALL have port iLEN, input, 4, message length; 0 encodes 16.
REQ-009 SHALL have port iDIV, input, 16, step period minus one, in cycles.
REQ-010 SHALL have port iSTART, input, 1, start-scroll pulse.
REQ-011 SHALL have port iSTOP, input, 1, stop-scroll pulse.
REQ-012 SHALL have port iPAUSE, input, 1, pause/resume toggle pulse.
REQ-013 SHALL have port iDIR, input, 1, direction; 0 = advance, 1 = reverse.
REQ-014 SHALL have ports oDIG1..oDIG4, output, SYM_W each, displayed symbols, digit 1 leftmost.
REQ-015 SHALL have port oBUSY, output, 1, high in RUN or HOLD.
REQ-016 SHALL have port oWRAP, output, 1, one-cycle pulse on position wrap.

Function
REQ-017 SHALL implement states IDLE, RUN, HOLD.
REQ-018 IDLE: iSTART -> RUN; latch LEN (0 -> 16) and DIV; pos = 0; divider = 0.
REQ-019 RUN: iSTOP -> IDLE; else iPAUSE -> HOLD; iSTART ignored.
REQ-020 HOLD: iSTOP -> IDLE; else iPAUSE -> RUN; pos and divider frozen.
REQ-021 iSTOP SHALL win over iSTART/iPAUSE in the same cycle.
REQ-022 Divider SHALL count 0..DIV in RUN; step when count == DIV, then count = 0, giving one step every DIV+1 cycles (DIV = 0 steps every cycle).
REQ-023 Step, iDIR = 0: pos = pos+1; at pos == LEN-1, pos = 0 and oWRAP pulses.
REQ-024 Step, iDIR = 1: pos = pos-1; at pos == 0, pos = LEN-1 and oWRAP pulses.
REQ-025 iDIR SHALL be sampled at each step, so direction changes mid-scroll take effect on the next step.
REQ-026 oDIGk SHALL be registered: buf[(pos+k-1) mod LEN] in RUN/HOLD, with one-cycle latency from pos/buffer change.
REQ-027 The mod-LEN rule SHALL hold for every LEN 1..16, including LEN < 4 (LEN = 1 gives all digits buf[0]).
REQ-028 oDIG1..4 SHALL be 0 (blank) in IDLE, from the cycle after entering IDLE.
REQ-029 Writes SHALL be accepted in any state; a write to a displayed index SHALL appear on the output one cycle after the write cycle.
REQ-030 Writes SHALL have no effect on pos, divider or state.
REQ-031 iLEN and iDIV changes while oBUSY SHALL be ignored until the next start.
REQ-032 oBUSY SHALL be registered and equal (state != IDLE).

Reset
REQ-033 iRST SHALL force state IDLE, pos 0, divider 0, LEN latch 16, DIV latch 0, oDIG1..4 = 0, oBUSY = 0, oWRAP = 0, and all buffer entries = 0.
REQ-034 iRST SHALL override all other inputs, including a same-cycle write.
REQ-035 iRST mid-RUN SHALL take effect on the next edge, with no wrap pulse.

Structure
REQ-036 Package scroll_pkg SHALL hold the state encoding, MSG_DEPTH, SYM_W and the BLANK = 0 constant.
REQ-037 The step-rate divider SHALL be sub-module scroll_rate_div (iCLK, iRST, enable, clear, DIV -> step pulse).
REQ-038 The message buffer SHALL be flip-flops with asynchronous (combinational) read.

Verification
REQ-039 Load buf[0..5] = 4,0,6,4,0,5 with iLEN = 6, iDIV = 0, iSTART -> after first step oDIG = 0,6,4,0; pos sequence 0..5,0; oWRAP high for exactly one cycle at 5->0.
REQ-040 iLEN = 3, buf[0..2] = 1,2,3, iDIV = 3 -> steps every 4 cycles; oDIG at pos 0 = 1,2,3,1; at pos 2 = 3,1,2,3.
REQ-041 During RUN, iPAUSE -> outputs frozen for 10 cycles; iPAUSE -> resume; the remaining divider count is preserved.
REQ-042 iDIR = 1 at pos 0, iLEN = 6 -> next step pos = 5 with oWRAP pulse; same-cycle iSTART+iSTOP in RUN -> IDLE, oDIG = 0.
REQ-043 iWR_EN to address pos+1 during HOLD -> oDIG2 updates the next cycle; iRST asserted mid-RUN -> all outputs 0 the next cycle, buffer reads 0 after restart.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling symbol display controller.
package scroll_pkg;

   localparam int MSG_DEPTH = 16;
   localparam int SYM_W     = 5;
   localparam int BLANK     = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // (pos + off) mod len for len in 1..16, pos < len, off < 4.
   // Three subtractions cover the worst case of len = 1 with off = 3.
   function automatic logic [3:0] wrap_idx(input logic [3:0] pos,
                                           input logic [1:0] off,
                                           input logic [4:0] len);
      logic [4:0] sum;
      sum = {1'b0, pos} + {3'b000, off};
      for (int i = 0; i < 3; i++) begin
         if (sum >= len) sum = sum - len;
      end
      return sum[3:0];
   endfunction

endpackage

// File: rtl/scroll_rate_div.sv
// Step-rate divider: emits one step every div+1 enabled cycles.
module scroll_rate_div (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        enable,
   input  logic        clear,
   input  logic [15:0] div,
   output logic        step
);

   logic [15:0] count_reg;

   assign step = enable && (count_reg == div);

   always_ff @(posedge iCLK) begin
      if (iRST || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= step ? 16'd0 : count_reg + 16'd1;
      end
   end

endmodule

// File: rtl/scroll_ctrl.sv
// Scrolls a message buffer across four registered display digits.
module scroll_ctrl #(
   parameter int MSG_DEPTH = scroll_pkg::MSG_DEPTH,
   parameter int SYM_W     = scroll_pkg::SYM_W
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iWR_EN,
   input  logic [3:0]       iWR_ADDR,
   input  logic [SYM_W-1:0] iWR_DATA,
   input  logic [3:0]       iLEN,
   input  logic [15:0]      iDIV,
   input  logic             iSTART,
   input  logic             iSTOP,
   input  logic             iPAUSE,
   input  logic             iDIR,
   output logic [SYM_W-1:0] oDIG1,
   output logic [SYM_W-1:0] oDIG2,
   output logic [SYM_W-1:0] oDIG3,
   output logic [SYM_W-1:0] oDIG4,
   output logic             oBUSY,
   output logic             oWRAP
);
   import scroll_pkg::*;

   state_t            state_reg, state_next;
   logic              start_go;
   logic              step;
   logic [3:0]        pos_reg;
   logic [4:0]        len_reg;
   logic [15:0]       div_reg;
   logic              busy_reg;
   logic              wrap_reg;
   logic [SYM_W-1:0]  msg_buf [MSG_DEPTH];
   logic [SYM_W-1:0]  dig_reg [4];
   logic [3:0]        rd_idx  [4];

   always_ff @(posedge iCLK) begin
      if (iRST) state_reg <= ST_IDLE;
      else      state_reg <= state_next;
   end

   // Stop always wins; start is only honoured from IDLE.
   always_comb begin
      state_next = state_reg;
      start_go   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (iSTART && !iSTOP) begin
               state_next = ST_RUN;
               start_go   = 1'b1;
            end
         end
         ST_RUN: begin
            if (iSTOP)       state_next = ST_IDLE;
            else if (iPAUSE) state_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (iSTOP)       state_next = ST_IDLE;
            else if (iPAUSE) state_next = ST_RUN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   scroll_rate_div u_rate_div (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .enable ((state_reg == ST_RUN) && !iSTOP),
      .clear  (start_go),
      .div    (div_reg),
      .step   (step)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         pos_reg  <= '0;
         len_reg  <= 5'd16;
         div_reg  <= '0;
         busy_reg <= 1'b0;
         wrap_reg <= 1'b0;
      end else begin
         busy_reg <= (state_next != ST_IDLE);
         wrap_reg <= 1'b0;
         if (start_go) begin
            pos_reg <= '0;
            len_reg <= (iLEN == 4'd0) ? 5'd16 : {1'b0, iLEN};
            div_reg <= iDIV;
         end else if (step) begin
            if (!iDIR) begin
               if ({1'b0, pos_reg} == len_reg - 5'd1) begin
                  pos_reg  <= '0;
                  wrap_reg <= 1'b1;
               end else begin
                  pos_reg <= pos_reg + 4'd1;
               end
            end else begin
               if (pos_reg == 4'd0) begin
                  pos_reg  <= 4'(len_reg - 5'd1);
                  wrap_reg <= 1'b1;
               end else begin
                  pos_reg <= pos_reg - 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge iCLK) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
         if (iRST)                                msg_buf[i] <= '0;
         else if (iWR_EN && iWR_ADDR == 4'(i))    msg_buf[i] <= iWR_DATA;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rd
         assign rd_idx[gi] = wrap_idx(pos_reg, 2'(gi), len_reg);
      end
   endgenerate

   always_ff @(posedge iCLK) begin
      for (int k = 0; k < 4; k++) begin
         if (iRST || state_reg == ST_IDLE) dig_reg[k] <= SYM_W'(BLANK);
         else                              dig_reg[k] <= msg_buf[rd_idx[k]];
      end
   end

   assign oDIG1 = dig_reg[0];
   assign oDIG2 = dig_reg[1];
   assign oDIG3 = dig_reg[2];
   assign oDIG4 = dig_reg[3];
   assign oBUSY = busy_reg;
   assign oWRAP = wrap_reg;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed checks of scroll_ctrl: scrolling, pause, direction, writes, stop and reset.
module tb_scroll_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [4:0]  wr_data;
   logic [3:0]  len;
   logic [15:0] div;
   logic        start, stop, pause, dir;
   logic [4:0]  dig1, dig2, dig3, dig4;
   logic        busy, wrap;
   logic [19:0] dig_w;

   int checks = 0;
   int errors = 0;
   logic [19:0] win1 [6];

   always #5 clk = ~clk;

   assign dig_w = {dig1, dig2, dig3, dig4};

   scroll_ctrl dut (
      .iCLK     (clk),
      .iRST     (rst),
      .iWR_EN   (wr_en),
      .iWR_ADDR (wr_addr),
      .iWR_DATA (wr_data),
      .iLEN     (len),
      .iDIV     (div),
      .iSTART   (start),
      .iSTOP    (stop),
      .iPAUSE   (pause),
      .iDIR     (dir),
      .oDIG1    (dig1),
      .oDIG2    (dig2),
      .oDIG3    (dig3),
      .oDIG4    (dig4),
      .oBUSY    (busy),
      .oWRAP    (wrap)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   function automatic logic [19:0] p4(input int a, input int b, input int c, input int d);
      return {5'(a), 5'(b), 5'(c), 5'(d)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input int data);
      wr_en   = 1'b1;
      wr_addr = 4'(addr);
      wr_data = 5'(data);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic go(input int l, input int d);
      len   = 4'(l);
      div   = 16'(d);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic halt();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      len = '0; div = '0; start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0;
      win1[0] = p4(4,0,6,4); win1[1] = p4(0,6,4,0); win1[2] = p4(6,4,0,5);
      win1[3] = p4(4,0,5,4); win1[4] = p4(0,5,4,0); win1[5] = p4(5,4,0,6);

      // Reset with a simultaneous write that must be discarded
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 5'd7;
      tick(); tick();
      wr_en = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_dig", dig_w, 0);
      rst = 1'b0;
      go(2, 0);
      tick();
      chk("rst_write_dropped", dig_w, 0);
      chk("busy_run", busy, 1);
      halt();

      // LEN 6, DIV 0: one step per cycle, wrap at 5 -> 0
      wr(0,4); wr(1,0); wr(2,6); wr(3,4); wr(4,0); wr(5,5);
      go(6, 0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("l6_dig_%0d", k), dig_w, win1[(k-1) % 6]);
         chk($sformatf("l6_wrap_%0d", k), wrap, (k == 6) ? 1 : 0);
      end
      halt();
      chk("stop_busy", busy, 0);
      tick();
      chk("stop_dig_blank", dig_w, 0);

      // LEN 3, DIV 3: one step every 4 cycles
      wr(0,1); wr(1,2); wr(2,3);
      go(3, 3);
      tick();                         // S+1
      chk("l3_pos0", dig_w, p4(1,2,3,1));
      tick(); tick(); tick();         // S+4
      chk("l3_pos0_hold", dig_w, p4(1,2,3,1));
      tick();                         // S+5
      chk("l3_pos1", dig_w, p4(2,3,1,2));
      tick(); tick(); tick();         // S+8
      chk("l3_pos1_hold", dig_w, p4(2,3,1,2));
      tick();                         // S+9
      chk("l3_pos2", dig_w, p4(3,1,2,3));
      tick(); tick();                 // S+11
      chk("l3_nowrap", wrap, 0);
      tick();                         // S+12
      chk("l3_wrap", wrap, 1);

      // Pause with divider at 3 of 3: resume must step on the first RUN cycle
      tick(); tick();                 // count = 2
      pause = 1'b1; tick(); pause = 1'b0;   // count -> 3, enter HOLD
      for (int k = 0; k < 10; k++) tick();
      chk("hold_frozen", dig_w, p4(1,2,3,1));
      chk("hold_busy", busy, 1);
      pause = 1'b1; tick(); pause = 1'b0;   // back to RUN
      tick();
      chk("resume_pos0", dig_w, p4(1,2,3,1));
      tick();
      chk("resume_step", dig_w, p4(2,3,1,2));
      halt();

      // Reverse from pos 0 with LEN 6 (buf = 1,2,3,4,0,5)
      dir = 1'b1;
      go(6, 7);
      for (int k = 0; k < 7; k++) tick();   // S+7
      chk("rev_nowrap", wrap, 0);
      tick();                                // S+8
      chk("rev_wrap", wrap, 1);
      tick();
      chk("rev_pos5", dig_w, p4(5,1,2,3));
      chk("rev_wrap_once", wrap, 0);
      dir = 1'b0;
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      chk("startstop_busy", busy, 0);
      tick();
      chk("startstop_dig", dig_w, 0);

      // Write into a displayed index while held
      go(6, 0);
      pause = 1'b1; tick(); pause = 1'b0;   // stepped to pos 1, now HOLD
      tick();
      chk("hold_pos1", dig_w, p4(2,3,4,0));
      wr(2, 9);
      chk("wr_not_early", dig2, 3);
      tick();
      chk("wr_visible", dig_w, p4(2,9,4,0));
      pause = 1'b1; tick(); pause = 1'b0;

      // Reset mid-RUN clears everything, buffer included
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_dig", dig_w, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_wrap", wrap, 0);
      go(0, 0);
      tick();
      chk("after_rst_buf", dig_w, 0);
      halt();

      // LEN 1 repeats buf[0] and wraps on every step
      wr(0, 7); wr(1, 3);
      go(1, 0);
      tick();
      chk("l1_dig", dig_w, p4(7,7,7,7));
      chk("l1_wrap_a", wrap, 1);
      tick();
      chk("l1_wrap_b", wrap, 1);
      halt();

      // LEN 2 window alternates
      go(2, 1);
      tick();
      chk("l2_pos0", dig_w, p4(7,3,7,3));
      tick(); tick();
      chk("l2_pos1", dig_w, p4(3,7,3,7));
      halt();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
